// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register and write-back formatter for the MIPS datapath.
// Each rising clock edge it captures the memory-stage result, picks the value
// to write back (ALU result, sized/sign-extended load data, or link address)
// and presents the register-file write port one cycle later.
//
// Parameters:
//   LINK_REG     destination register used for link writes (jal/jalr)
//
// Ports:
//   clock        rising-edge clock shared with registerfile
//   reset_n      asynchronous active-low reset
//   Stall        hold current contents (no capture)
//   Flush        capture a bubble instead of MEM inputs (wins over Stall)
//   MemValid     MEM stage holds a real instruction
//   MemRegWrite  instruction writes a register
//   MemtoReg     1 = load data, 0 = ALU result
//   MemLink      1 = write PCPlus4 to LINK_REG
//   MemDest      destination register number
//   LoadType     0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5-7 behave as lw
//   ALUResult    ALU result / effective address
//   ReadDataMem  raw (big-endian) data-memory word
//   PCPlus4      link address
//   WriteReg     registerfile WriteReg
//   WriteData    registerfile WriteData
//   RegWrite     registerfile RegWrite
//   MisalignErr  registered flag: the captured load was misaligned and dropped
//   RetireCount  committed-write counter
//
// Optional feature: define MEM_WB_RETIRE_CNT_EN to build the retire counter.
// Without it RetireCount is tied to zero.
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        MemValid,
  input  logic        MemRegWrite,
  input  logic        MemtoReg,
  input  logic        MemLink,
  input  logic [4:0]  MemDest,
  input  logic [2:0]  LoadType,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadDataMem,
  input  logic [31:0] PCPlus4,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        MisalignErr,
  output logic [31:0] RetireCount
);

  logic [1:0]  w_offset;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;
  logic        w_typeMisaligned;
  logic        w_misaligned;
  logic [4:0]  w_dest;
  logic [31:0] w_data;
  logic        w_regWrite;

  logic [4:0]  r_writeReg;
  logic [31:0] r_writeData;
  logic        r_regWrite;
  logic        r_misalignErr;

  assign w_offset = ALUResult[1:0];

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    w_byte = ReadDataMem[31:24];
    case (w_offset)
      2'd0: w_byte = ReadDataMem[31:24];
      2'd1: w_byte = ReadDataMem[23:16];
      2'd2: w_byte = ReadDataMem[15:8];
      2'd3: w_byte = ReadDataMem[7:0];
      default: w_byte = ReadDataMem[31:24];
    endcase
  end

  // Halfword lane is chosen by offset[1]; offset[0] only flags misalignment.
  assign w_half = w_offset[1] ? ReadDataMem[15:0] : ReadDataMem[31:16];

  // Size/extend the load and decide whether its offset is legal for its size.
  // Undefined LoadType codes fall into the word case.
  always_comb begin
    w_loadData       = ReadDataMem;
    w_typeMisaligned = 1'b0;
    case (LoadType)
      3'd1: begin
        w_loadData       = {{16{w_half[15]}}, w_half};
        w_typeMisaligned = w_offset[0];
      end
      3'd2: begin
        w_loadData       = {16'h0000, w_half};
        w_typeMisaligned = w_offset[0];
      end
      3'd3: w_loadData = {{24{w_byte[7]}}, w_byte};
      3'd4: w_loadData = {24'h000000, w_byte};
      default: begin
        w_loadData       = ReadDataMem;
        w_typeMisaligned = (w_offset != 2'b00);
      end
    endcase
  end

  // A link write ignores MemtoReg, so it can never be a misaligned load.
  assign w_misaligned = MemValid & MemtoReg & ~MemLink & w_typeMisaligned;
  assign w_dest       = MemLink ? LINK_REG : MemDest;
  assign w_data       = MemLink ? PCPlus4 : (MemtoReg ? w_loadData : ALUResult);
  assign w_regWrite   = MemValid & MemRegWrite & ~w_misaligned & (w_dest != 5'd0);

  // Pipeline register: Flush inserts a bubble even when stalled; Stall holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_writeReg    <= 5'd0;
      r_writeData   <= 32'd0;
      r_regWrite    <= 1'b0;
      r_misalignErr <= 1'b0;
    end else if (Flush) begin
      r_writeReg    <= 5'd0;
      r_writeData   <= 32'd0;
      r_regWrite    <= 1'b0;
      r_misalignErr <= 1'b0;
    end else if (!Stall) begin
      r_writeReg    <= w_dest;
      r_writeData   <= w_data;
      r_regWrite    <= w_regWrite;
      r_misalignErr <= w_misaligned;
    end
  end

  assign WriteReg    = r_writeReg;
  assign WriteData   = r_writeData;
  assign RegWrite    = r_regWrite;
  assign MisalignErr = r_misalignErr;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic        w_capture;
  logic [31:0] r_retireCount;

  assign w_capture = ~Flush & ~Stall;

  // Counts each captured instruction that will commit; wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_retireCount <= 32'd0;
    end else if (w_capture && w_regWrite) begin
      r_retireCount <= r_retireCount + 32'd1;
    end
  end

  assign RetireCount = r_retireCount;
`else
  assign RetireCount = 32'd0;
`endif

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and write-back formatter for the MIPS datapath. Captures the memory-stage result each cycle, selects and formats the write-back value (ALU result, sized/sign-extended load data, or link address), and drives the register file write port (WriteReg, WriteData, RegWrite) one cycle later. Sits directly upstream of registerfile; its outputs connect port-for-port to the register file write inputs.

## Interface
Parameters:
- LINK_REG, 31, destination register forced for link writes (jal/jalr)

Ports:
- clock  in  1  rising-edge clock shared with registerfile
- reset_n  in  1  asynchronous active-low reset
- Stall  in  1  hold current contents (no capture)
- Flush  in  1  capture a bubble instead of MEM inputs
- MemValid  in  1  MEM stage holds a real instruction
- MemRegWrite  in  1  instruction writes a register
- MemtoReg  in  1  1 = load data, 0 = ALU result
- MemLink  in  1  1 = write PCPlus4 to LINK_REG
- MemDest  in  5  destination register number
- LoadType  in  3  0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5-7 treated as lw
- ALUResult  in  32  ALU result / effective address
- ReadDataMem  in  32  raw data-memory word
- PCPlus4  in  32  link address
- WriteReg  out  5  to registerfile WriteReg
- WriteData  out  32  to registerfile WriteData
- RegWrite  out  1  to registerfile RegWrite
- MisalignErr  out  1  one-cycle pulse: misaligned load dropped
- RetireCount  out  32  committed-write counter (see Configuration)

## Operation
- Capture condition at rising clock: Flush=1 -> bubble (RegWrite=0, WriteReg=0, WriteData=0, MisalignErr=0); else Stall=1 -> all outputs hold; else capture MEM inputs. Flush wins over Stall.
- Write enable: RegWrite = MemValid & MemRegWrite & ~misaligned & (dest != 0).
- Destination: MemLink=1 -> LINK_REG; else MemDest. Destination 0 never written (RegWrite forced 0, WriteData still captured).
- Data select priority: MemLink -> PCPlus4; else MemtoReg -> formatted load; else ALUResult.
- Load formatting, big-endian, offset = ALUResult[1:0]: byte at offset 0 = ReadDataMem[31:24], offset 3 = [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0]. lb/lh sign-extend to 32 bits; lbu/lhu zero-extend; lw passes word.
- Misalignment (only when MemValid & MemtoReg & ~MemLink): lh/lhu with offset[0]=1, lw with offset!=0. Result: RegWrite=0 and MisalignErr=1 for the captured cycle; lb/lbu never misaligned.
- MisalignErr is registered with the other outputs: set only on a capture of a misaligned load, cleared on the next capture or bubble; holds during Stall.

## Timing
- Latency 1 cycle: inputs valid before edge N appear on outputs after edge N; registerfile commits them at edge N+1.
- All outputs registered; no combinational path input -> output.
- Reset (reset_n=0, asynchronous, immediate): WriteReg=0, WriteData=0, RegWrite=0, MisalignErr=0, RetireCount=0. Release is synchronous to next rising edge; first capture at first edge with reset_n=1.
- Reset mid-stall or mid-flush: reset overrides both; pending instruction is discarded.
- Stall for K cycles: outputs identical for K+1 cycles; RegWrite stays asserted across stall (registerfile rewrites same value, idempotent).

## Configuration
- MEM_WB_RETIRE_CNT_EN defined: RetireCount increments by 1 (mod 2^32, wraps 0xFFFFFFFF -> 0) at each edge that captures an instruction with resulting RegWrite=1; no increment on stall, bubble, dest 0, or misaligned load.
- Not defined: counter logic absent, RetireCount constant 0.

## Test plan
- Reset: drive reset_n=0 mid-cycle with RegWrite=1 on outputs -> all outputs 0 immediately; after release, ALUResult=0x12345678, MemDest=5, MemRegWrite=1 -> WriteReg=5, WriteData=0x12345678, RegWrite=1 one edge later.
- Loads: ReadDataMem=0x80FF7F01; lb offset 0 -> 0xFFFFFF80; lbu offset 1 -> 0x000000FF; lh offset 2 -> 0x00007F01; lhu offset 0 -> 0x000080FF; lw offset 0 -> 0x80FF7F01.
- Misaligned: lw at ALUResult=0x1002 -> RegWrite=0, MisalignErr=1 for one captured cycle; following valid ALU op clears it.
- Link and $0: MemLink=1, PCPlus4=0x00400010, MemDest=7 -> WriteReg=31, WriteData=0x00400010; MemDest=0 ALU write -> RegWrite=0.
- Stall/Flush: Stall=1 for 3 cycles -> outputs frozen 4 cycles; Stall=1 and Flush=1 together -> bubble (RegWrite=0).
- Counter (macro defined): 10 valid writes, 2 to $0, 1 misaligned, 1 flushed -> RetireCount=6; preload near wrap via 2^32 writes optional, else check increment from 0.
